mem_port_arbiter: RTL and testbench

- Shares the core's single-port unified memory between instruction fetch (IF) and the load/store unit (LSU).
- Arbitrates between the two, holds one transaction outstanding at a time and routes the response back to the owner.
- Bounds IF starvation under back-to-back LSU traffic and flags memory responses that never arrive.
- Sits inside proc_top, between the fetch/LSU stages and the memory model.

---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and the LSU.
// Ports: Clk_Core/Rst_Core_N clock and async active-low reset;
//   If_*  fetch request/grant/response; Lsu_* load/store request/grant/response;
//   Mem_* memory request and response; Bus_Err timeout pulse; Owner 0=IF, 1=LSU.
module mem_port_arbiter #(
    parameter int DWIDTH     = 32,
    parameter int AWIDTH     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                Clk_Core,
    input  logic                Rst_Core_N,
    input  logic                If_Req,
    input  logic [AWIDTH-1:0]   If_Addr,
    output logic                If_Gnt,
    output logic                If_Rvalid,
    output logic [DWIDTH-1:0]   If_Rdata,
    input  logic                Lsu_Req,
    input  logic                Lsu_We,
    input  logic [DWIDTH/8-1:0] Lsu_Be,
    input  logic [AWIDTH-1:0]   Lsu_Addr,
    input  logic [DWIDTH-1:0]   Lsu_Wdata,
    output logic                Lsu_Gnt,
    output logic                Lsu_Rvalid,
    output logic [DWIDTH-1:0]   Lsu_Rdata,
    output logic                Mem_Req,
    output logic                Mem_We,
    output logic [DWIDTH/8-1:0] Mem_Be,
    output logic [AWIDTH-1:0]   Mem_Addr,
    output logic [DWIDTH-1:0]   Mem_Wdata,
    input  logic                Mem_Gnt,
    input  logic                Mem_Rvalid,
    input  logic [DWIDTH-1:0]   Mem_Rdata,
    output logic                Bus_Err,
    output logic                Owner
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nx;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic we_q, lsu_win, if_win, rsp, tmo;
    logic [DWIDTH/8-1:0] be_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] wdata_q;

    always_ff @(posedge Clk_Core or negedge Rst_Core_N)
        if (!Rst_Core_N) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        If_Gnt = 1'b0;
        Lsu_Gnt = 1'b0;
        Mem_Req = 1'b0;
        Bus_Err = 1'b0;
        rsp = 1'b0;
        // IF overrides the LSU only once it has been passed over STARVE_MAX times in a row
        lsu_win = Lsu_Req && !(If_Req && starve_cnt == 4'(STARVE_MAX));
        if_win = If_Req && !lsu_win;
        tmo = tmo_cnt == 8'(TIMEOUT);
        case (state)
            IDLE: begin
                If_Gnt = if_win && Rst_Core_N;
                Lsu_Gnt = lsu_win && Rst_Core_N;
                if (if_win || lsu_win) state_nx = ISSUE;
            end
            ISSUE: begin
                Mem_Req = 1'b1;
                if (Mem_Gnt) state_nx = WAIT;
            end
            WAIT: begin
                rsp = Mem_Rvalid || tmo;
                Bus_Err = tmo && !Mem_Rvalid;
                if (rsp) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge Clk_Core or negedge Rst_Core_N)
        if (!Rst_Core_N) begin
            Owner <= 1'b0;
            we_q <= 1'b0;
            be_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            starve_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (If_Gnt || Lsu_Gnt) begin
                Owner <= Lsu_Gnt;
                we_q <= Lsu_Gnt && Lsu_We;
                be_q <= Lsu_Gnt ? Lsu_Be : '1;
                addr_q <= Lsu_Gnt ? Lsu_Addr : If_Addr;
                wdata_q <= Lsu_Gnt ? Lsu_Wdata : '0;
                starve_cnt <= (Lsu_Gnt && If_Req) ? starve_cnt + 4'd1 : '0;
            end
            // Zero outside WAIT, so it starts from 0 on every WAIT entry
            tmo_cnt <= (state == WAIT) ? tmo_cnt + 8'd1 : '0;
        end

    assign Mem_We = we_q;
    assign Mem_Be = be_q;
    assign Mem_Addr = addr_q;
    assign Mem_Wdata = wdata_q;
    assign If_Rvalid = rsp && !Owner;
    assign Lsu_Rvalid = rsp && Owner;
    // A timeout response carries zero data
    assign If_Rdata = (If_Rvalid && Mem_Rvalid) ? Mem_Rdata : '0;
    assign Lsu_Rdata = (Lsu_Rvalid && Mem_Rvalid) ? Mem_Rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [3:0]  lsu_be = 4'hf;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_err, owner;
    int checks = 0;
    int failures = 0;

    mem_port_arbiter #(.DWIDTH(32), .AWIDTH(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
        .Clk_Core(clk), .Rst_Core_N(rst_n),
        .If_Req(if_req), .If_Addr(if_addr), .If_Gnt(if_gnt), .If_Rvalid(if_rvalid), .If_Rdata(if_rdata),
        .Lsu_Req(lsu_req), .Lsu_We(lsu_we), .Lsu_Be(lsu_be), .Lsu_Addr(lsu_addr), .Lsu_Wdata(lsu_wdata),
        .Lsu_Gnt(lsu_gnt), .Lsu_Rvalid(lsu_rvalid), .Lsu_Rdata(lsu_rdata),
        .Mem_Req(mem_req), .Mem_We(mem_we), .Mem_Be(mem_be), .Mem_Addr(mem_addr), .Mem_Wdata(mem_wdata),
        .Mem_Gnt(mem_gnt), .Mem_Rvalid(mem_rvalid), .Mem_Rdata(mem_rdata),
        .Bus_Err(bus_err), .Owner(owner)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"}, 64'(if_gnt), 0);
        chk({tag, "_lsu_gnt"}, 64'(lsu_gnt), 0);
        chk({tag, "_if_rvalid"}, 64'(if_rvalid), 0);
        chk({tag, "_lsu_rvalid"}, 64'(lsu_rvalid), 0);
        chk({tag, "_if_rdata"}, 64'(if_rdata), 0);
        chk({tag, "_lsu_rdata"}, 64'(lsu_rdata), 0);
        chk({tag, "_mem_req"}, 64'(mem_req), 0);
        chk({tag, "_bus_err"}, 64'(bus_err), 0);
        chk({tag, "_owner"}, 64'(owner), 0);
    endtask

    initial begin
        logic exp_lsu [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        #3;
        chk_all_zero("rst");
        chk("rst_mem_addr", 64'(mem_addr), 0);
        chk("rst_mem_be", 64'(mem_be), 0);
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        chk_all_zero("post_rst");

        // Fetch only
        if_req = 1'b1; if_addr = 32'h100; #1;
        chk("f_if_gnt", 64'(if_gnt), 1);
        chk("f_lsu_gnt", 64'(lsu_gnt), 0);
        chk("f_mem_req0", 64'(mem_req), 0);
        step(); if_req = 1'b0; if_addr = 32'h0; mem_gnt = 1'b1; #1;
        chk("f_mem_req", 64'(mem_req), 1);
        chk("f_mem_addr", 64'(mem_addr), 64'h100);
        chk("f_mem_we", 64'(mem_we), 0);
        chk("f_mem_be", 64'(mem_be), 64'hf);
        chk("f_mem_wdata", 64'(mem_wdata), 0);
        chk("f_owner", 64'(owner), 0);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093; #1;
        chk("f_mem_req_drop", 64'(mem_req), 0);
        chk("f_if_rvalid", 64'(if_rvalid), 1);
        chk("f_if_rdata", 64'(if_rdata), 64'h00500093);
        chk("f_lsu_rvalid", 64'(lsu_rvalid), 0);
        chk("f_lsu_rdata", 64'(lsu_rdata), 0);
        // Stray response while idle must be ignored
        step(); mem_rdata = 32'h55aa55aa; #1;
        chk("stray_if_rvalid", 64'(if_rvalid), 0);
        chk("stray_lsu_rvalid", 64'(lsu_rvalid), 0);
        chk("stray_if_rdata", 64'(if_rdata), 0);
        chk("stray_bus_err", 64'(bus_err), 0);
        mem_rvalid = 1'b0;

        // Simultaneous requests: LSU wins with starve_cnt=0
        if_req = 1'b1; if_addr = 32'h104;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h2000; #1;
        chk("s_lsu_gnt", 64'(lsu_gnt), 1);
        chk("s_if_gnt", 64'(if_gnt), 0);
        step(); lsu_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("s_mem_addr", 64'(mem_addr), 64'h2000);
        chk("s_owner", 64'(owner), 1);
        chk("s_if_gnt_busy", 64'(if_gnt), 0);
        step(); if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h12345678; #1;
        chk("s_lsu_rvalid", 64'(lsu_rvalid), 1);
        chk("s_lsu_rdata", 64'(lsu_rdata), 64'h12345678);
        chk("s_if_rvalid", 64'(if_rvalid), 0);
        chk("s_if_rdata", 64'(if_rdata), 0);
        step(); mem_rvalid = 1'b0; mem_rdata = '0;

        // Store with Mem_Gnt delayed 3 cycles; inputs change after the grant
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0011; lsu_addr = 32'h2004; lsu_wdata = 32'hdeadbeef; #1;
        chk("st_lsu_gnt", 64'(lsu_gnt), 1);
        step(); lsu_req = 1'b0; lsu_we = 1'b0; lsu_be = 4'hf; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_gnt = (i == 3); #1;
            chk($sformatf("st_mem_req%0d", i), 64'(mem_req), 1);
            chk($sformatf("st_mem_we%0d", i), 64'(mem_we), 1);
            chk($sformatf("st_mem_be%0d", i), 64'(mem_be), 64'h3);
            chk($sformatf("st_mem_addr%0d", i), 64'(mem_addr), 64'h2004);
            chk($sformatf("st_mem_wdata%0d", i), 64'(mem_wdata), 64'hdeadbeef);
            step();
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b1; #1;
        chk("st_mem_req_drop", 64'(mem_req), 0);
        chk("st_lsu_rvalid", 64'(lsu_rvalid), 1);
        chk("st_lsu_rdata", 64'(lsu_rdata), 0);
        step(); mem_rvalid = 1'b0; #1;
        chk("st_lsu_rvalid_end", 64'(lsu_rvalid), 0);

        // Starvation: both requesting continuously
        if_req = 1'b1; if_addr = 32'h200; lsu_req = 1'b1; lsu_addr = 32'h3000;
        for (int t = 0; t < 6; t++) begin
            #1;
            chk($sformatf("sv_lsu_gnt%0d", t), 64'(lsu_gnt), 64'(exp_lsu[t]));
            chk($sformatf("sv_if_gnt%0d", t), 64'(if_gnt), 64'(!exp_lsu[t]));
            step(); mem_gnt = 1'b1; #1;
            chk($sformatf("sv_owner%0d", t), 64'(owner), 64'(exp_lsu[t]));
            chk($sformatf("sv_addr%0d", t), 64'(mem_addr), exp_lsu[t] ? 64'h3000 : 64'h200);
            step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1000 + 32'(t); #1;
            chk($sformatf("sv_if_rv%0d", t), 64'(if_rvalid), 64'(!exp_lsu[t]));
            chk($sformatf("sv_lsu_rv%0d", t), 64'(lsu_rvalid), 64'(exp_lsu[t]));
            step(); mem_rvalid = 1'b0; mem_rdata = '0;
        end
        if_req = 1'b0; lsu_req = 1'b0;

        // Timeout: memory grants but never responds
        if_req = 1'b1; if_addr = 32'h400; #1;
        chk("to_if_gnt", 64'(if_gnt), 1);
        step(); if_req = 1'b0; mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("to_bus_err_w%0d", k), 64'(bus_err), 0);
            chk($sformatf("to_if_rv_w%0d", k), 64'(if_rvalid), 0);
            step();
        end
        #1;
        chk("to_bus_err", 64'(bus_err), 1);
        chk("to_if_rvalid", 64'(if_rvalid), 1);
        chk("to_if_rdata", 64'(if_rdata), 0);
        chk("to_lsu_rvalid", 64'(lsu_rvalid), 0);
        step(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h5000; #1;
        chk("to_bus_err_end", 64'(bus_err), 0);
        chk("to_if_rvalid_end", 64'(if_rvalid), 0);
        chk("to_next_lsu_gnt", 64'(lsu_gnt), 1);

        // Reset while waiting on an LSU load
        step(); lsu_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("rm_owner", 64'(owner), 1);
        step(); mem_gnt = 1'b0; #1;
        rst_n = 1'b0; if_req = 1'b1; #1;
        chk_all_zero("rm_in_rst");
        step(); #1;
        chk_all_zero("rm_in_rst2");
        @(negedge clk) rst_n = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hbad0bad0;
        step();
        chk_all_zero("rm_late_rvalid");
        mem_rvalid = 1'b0; mem_rdata = '0; if_req = 1'b1; if_addr = 32'h300; #1;
        chk("rm_if_gnt", 64'(if_gnt), 1);
        step(); if_req = 1'b0; mem_gnt = 1'b1; #1;
        chk("rm_mem_addr", 64'(mem_addr), 64'h300);
        chk("rm_mem_req", 64'(mem_req), 1);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0badf00d; #1;
        chk("rm_if_rvalid", 64'(if_rvalid), 1);
        chk("rm_if_rdata", 64'(if_rdata), 64'h0badf00d);
        step(); mem_rvalid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
